// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_N = 16;

    // Counter width for n steps; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_w(DIV_N);

    localparam logic [DIV_N-1:0] ALL_ONES = '1;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division step (one quotient bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int N = 16
) (
    input  logic [N-1:0] rem,
    input  logic         next_bit,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] new_rem,
    output logic         q_bit
);

    // Extra top bit holds the borrow of {rem, next_bit} - divisor.
    logic [N+1:0] w_diff;
    logic         w_borrow;

    assign w_diff   = {1'b0, rem, next_bit} - {2'b00, divisor};
    assign w_borrow = w_diff[N+1];
    assign q_bit    = ~w_borrow;
    assign new_rem  = w_borrow ? {rem[N-2:0], next_bit} : w_diff[N-1:0];

endmodule
`default_nettype wire

// File: rtl/div32_16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div32_16_seq
//  Description : 2N/N unsigned restoring divider, one quotient bit per cycle,
//                valid/ready on input and output.
//  Revision    : 1.0 - initial release
// ============================================================================
module div32_16_seq
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = cnt_w(N);

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_sh;
    logic [N-1:0]  r_quo;
    logic [N-1:0]  r_div;
    logic [CW-1:0] r_cnt;
    logic          r_dbz;
    logic          r_ovf;

    logic          w_accept;
    logic          w_zero;
    logic          w_big;
    logic [N-1:0]  w_step_rem;
    logic          w_step_q;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_zero   = (divisor == '0);
    assign w_big    = (dividend[2*N-1:N] >= divisor);

    div_step #(.N(N)) u_step (
        .rem      (r_rem),
        .next_bit (r_sh[N-1]),
        .divisor  (r_div),
        .new_rem  (w_step_rem),
        .q_bit    (w_step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = (w_zero || w_big) ? DONE : CALC;
            CALC: if (r_cnt == '0) w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_sh  <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dbz <= 1'b0;
                        r_ovf <= 1'b0;
                        // Divide-by-zero wins over overflow when both apply.
                        if (w_zero) begin
                            r_dbz <= 1'b1;
                            r_quo <= '1;
                            r_rem <= dividend[N-1:0];
                        end else if (w_big) begin
                            r_ovf <= 1'b1;
                            r_quo <= '1;
                            r_rem <= '1;
                        end else begin
                            r_rem <= dividend[2*N-1:N];
                            r_sh  <= dividend[N-1:0];
                            r_div <= divisor;
                            r_quo <= '0;
                            r_cnt <= CW'(N-1);
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_sh  <= {r_sh[N-2:0], 1'b0};
                    r_quo <= {r_quo[N-2:0], w_step_q};
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_div32_16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div32_16_seq
//  Description : Directed self-checking bench for div32_16_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div32_16_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div32_16_seq #(.N(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents an operation at a falling edge; the next rising edge is cycle 0.
    task automatic start(input logic [31:0] dd, input logic [15:0] dv);
        @(negedge clk);
        chk("start_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Cycle k is sampled at the falling edge after rising edge k-1.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) cyc = 99;
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] dd, input logic [15:0] dv,
                          input int lat, input logic [15:0] q, input logic [15:0] r,
                          input logic dz, input logic ov);
        int cyc;
        start(dd, dv);
        wait_valid(cyc);
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        chk({tag, "_quotient"}, 32'(quotient), 32'(q));
        chk({tag, "_remainder"}, 32'(remainder), 32'(r));
        chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(dz));
        chk({tag, "_overflow"}, 32'(overflow), 32'(ov));
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        release_result();
    endtask

    initial begin
        int cyc;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_flags", {30'd0, div_by_zero, overflow}, 32'd0);

        run_op("norm_1000000_1234", 32'h000F4240, 16'h04D2, 17, 16'h032A, 16'h01CC, 1'b0, 1'b0);
        run_op("max_legal", 32'hFFFE0001, 16'hFFFF, 17, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        run_op("div_zero", 32'h12345678, 16'h0000, 1, 16'hFFFF, 16'h5678, 1'b1, 1'b0);
        run_op("ovf", 32'h00010000, 16'h0001, 1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        run_op("zero_and_big", 32'hFFFF0000, 16'h0000, 1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op("small", 32'd1000, 16'd3, 17, 16'd333, 16'd1, 1'b0, 1'b0);

        // Output backpressure with a competing request held on the input.
        start(32'd50000, 16'd7);
        wait_valid(cyc);
        chk("bp_latency", 32'(cyc), 32'd17);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = 32'd999;
            divisor  = 16'd10;
            @(negedge clk);
            chk("bp_hold", {out_valid, in_ready, 14'd0, quotient}, {1'b1, 1'b0, 14'd0, 16'd7142});
            chk("bp_hold_rem", 32'(remainder), 32'd6);
        end
        in_valid = 1'b0;
        release_result();
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_quotient", 32'(quotient), 32'd7142);

        // Reset in the middle of a calculation.
        start(32'h000F4240, 16'h04D2);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        run_op("post_rst_100_7", 32'd100, 16'd7, 17, 16'd14, 16'd2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
